pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage core. It drives the stall (hold) and flush (bubble-insert, the pipeline registers' rst_ir input) controls of the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards, taken branches and data-memory wait states, and produces the EX-stage operand forwarding selects. A 4-state FSM covers multi-cycle memory waits and timeout error reporting.

Parameters:
MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before mem_err is raised.
CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
clk  in  1  core clock, rising edge.
rst  in  1  asynchronous, active-low reset.
id_rs1, id_rs2  in  5  ID-stage source register indices.
id_rs1_used, id_rs2_used  in  1  ID-stage instruction reads rs1 / rs2.
ex_rs1, ex_rs2  in  5  EX-stage source register indices, used for forwarding.
ex_wr_index, ex_wr_en, ex_data_sel  in  5/1/2  ID/EX writeback control.
mem_wr_index, mem_wr_en, mem_data_sel  in  5/1/2  EX/MEM writeback control.
wb_wr_index, wb_wr_en  in  5/1  MEM/WB writeback control.
branch_taken  in  1  EX-stage branch/jump resolved as taken.
mem_req  in  1  MEM stage has an active load or store.
mem_ready  in  1  data memory has completed the access this cycle.
stall_pc, stall_if_id, stall_id_ex, stall_ex_mem  out  1  hold the register.
flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb  out  1  bubble (wr_en<=0).
fwd_a, fwd_b  out  2  EX operand select: 00 register file, 01 EX/MEM, 10 MEM/WB.
mem_err  out  1  sticky memory-timeout flag.
stall_cnt  out  CNT_W  saturating count of cycles with stall_pc=1.

Behaviour:
- data_sel encoding: 00 ALU, 01 LOAD, 10 PC+4, 11 IMM.
- Register x0 never matches: any comparison with index 0 is false.
- While rst=0:
  - state=RUN, stall_cnt=0, mem_err=0.
  - All flush_*=1, all stall_*=0, fwd_a=fwd_b=00.
- Control outputs are combinational from state and inputs (zero latency). State, counters and mem_err are registered.
- FSM states: RUN, MEM_WAIT, TRAP.
- RUN, evaluated in priority order:
  1. mem_req & !mem_ready: assert stall_pc, stall_if_id, stall_id_ex, stall_ex_mem and flush_mem_wb. Next state MEM_WAIT; wait_cnt<=1.
  2. Else branch_taken: assert flush_if_id and flush_id_ex. No stalls; PC takes the target. A same-cycle load-use hazard is ignored.
  3. Else load-use: ex_wr_en & ex_data_sel==LOAD & ((id_rs1_used & id_rs1==ex_wr_index) | (id_rs2_used & id_rs2==ex_wr_index)). Assert stall_pc, stall_if_id and flush_id_ex. This gives exactly one bubble, because the next cycle's EX holds the bubble with wr_en=0.
- MEM_WAIT:
  - Same freeze outputs as RUN case 1; branch_taken is ignored because EX is frozen and the branch is re-evaluated after the wait.
  - mem_ready=1: drop the freeze outputs this cycle, clear wait_cnt and go to RUN.
  - Else, if wait_cnt==MEM_TIMEOUT: set mem_err and go to TRAP. Otherwise wait_cnt++.
- TRAP:
  - Assert all flush_* and stall_pc every cycle.
  - Exit only on reset.
- Forwarding, per operand X in {rs1, rs2}:
  - 01 if mem_wr_en & mem_data_sel!=LOAD & mem_wr_index==ex_X.
  - Else 10 if wb_wr_en & wb_wr_index==ex_X.
  - Else 00.
  - Forwarding is active in all states.
- stall_cnt increments on every cycle with stall_pc=1 and saturates at all-ones.
- Asynchronous reset mid-MEM_WAIT or in TRAP: immediate return to RUN with counters cleared.

Decomposition:
- Shared include pipe_ctrl_defs.vh holds:
  - the data_sel encodings (DSEL_ALU, DSEL_LOAD, DSEL_PC4, DSEL_IMM);
  - the FWD_* select encodings;
  - the FSM state encodings.
- One natural sub-module: fwd_sel_unit, combinational forwarding compare for one operand, instantiated twice.

Test Plan:
1. Load-use hazard: ex_wr_index=5, ex_data_sel=01, ex_wr_en=1, id_rs1=5, id_rs1_used=1 -> that cycle stall_pc=stall_if_id=flush_id_ex=1. Next cycle, with ex_wr_en=0: all 0; stall_cnt=1.
2. Branch priority: branch_taken=1 together with the load-use condition of scenario 1 -> flush_if_id=flush_id_ex=1, stall_pc=0.
3. Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 -> freeze plus flush_mem_wb for 3 cycles, all released on the 4th cycle, state returns to RUN.
4. Timeout: mem_ready held 0 with MEM_TIMEOUT=4 -> mem_err=1 after the 4th wait cycle, TRAP asserts all flush_*; rst=0 clears mem_err and stall_cnt.
5. Forwarding: ex_rs1=ex_rs2=7, mem_wr_index=7 ALU write, wb_wr_index=7 -> fwd_a=fwd_b=01. With mem_wr_en=0 -> 10. With all indices 0 -> 00.
6. Counter saturation: CNT_W=4 with 20 stall cycles -> stall_cnt=15.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: writeback data select,
// forwarding select and FSM state.
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] DSEL_ALU  = 2'b00;
    localparam logic [1:0] DSEL_LOAD = 2'b01;
    localparam logic [1:0] DSEL_PC4  = 2'b10;
    localparam logic [1:0] DSEL_IMM  = 2'b11;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_TRAP     = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel_unit.sv
// Forwarding compare for one EX operand; purely combinational.
// EX/MEM wins over MEM/WB; loads in EX/MEM cannot forward yet, x0 never matches.
module fwd_sel_unit
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] ex_rs_i,
    input  logic [4:0] mem_wr_index_i,
    input  logic       mem_wr_en_i,
    input  logic [1:0] mem_data_sel_i,
    input  logic [4:0] wb_wr_index_i,
    input  logic       wb_wr_en_i,
    output logic [1:0] fwd_o
);

    always_comb begin
        fwd_o = FWD_RF;
        if (ex_rs_i != 5'd0) begin
            if (mem_wr_en_i && (mem_data_sel_i != DSEL_LOAD) && (mem_wr_index_i == ex_rs_i))
                fwd_o = FWD_EXMEM;
            else if (wb_wr_en_i && (wb_wr_index_i == ex_rs_i))
                fwd_o = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer and operand forwarding for the 5-stage core.
// Controls are combinational from state and inputs; state, counters and mem_err are registered.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_wr_index,
    input  logic             ex_wr_en,
    input  logic [1:0]       ex_data_sel,
    input  logic [4:0]       mem_wr_index,
    input  logic             mem_wr_en,
    input  logic [1:0]       mem_data_sel,
    input  logic [4:0]       wb_wr_index,
    input  logic             wb_wr_en,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             stall_ex_mem,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic             flush_mem_wb,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [WW-1:0]     wait_cnt_q, wait_cnt_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [3:0]        stall_v, flush_v;   // {pc/if_id... } ordering: [3]=pc|if_id, see assigns
    logic [1:0]        fwd_a_raw, fwd_b_raw;
    logic              load_use;

    fwd_sel_unit u_fwd_a (
        .ex_rs_i        (ex_rs1),
        .mem_wr_index_i (mem_wr_index),
        .mem_wr_en_i    (mem_wr_en),
        .mem_data_sel_i (mem_data_sel),
        .wb_wr_index_i  (wb_wr_index),
        .wb_wr_en_i     (wb_wr_en),
        .fwd_o          (fwd_a_raw)
    );

    fwd_sel_unit u_fwd_b (
        .ex_rs_i        (ex_rs2),
        .mem_wr_index_i (mem_wr_index),
        .mem_wr_en_i    (mem_wr_en),
        .mem_data_sel_i (mem_data_sel),
        .wb_wr_index_i  (wb_wr_index),
        .wb_wr_en_i     (wb_wr_en),
        .fwd_o          (fwd_b_raw)
    );

    assign load_use = ex_wr_en && (ex_data_sel == DSEL_LOAD) && (ex_wr_index != 5'd0) &&
                      ((id_rs1_used && (id_rs1 == ex_wr_index)) ||
                       (id_rs2_used && (id_rs2 == ex_wr_index)));

    // stall_v = {pc, if_id, id_ex, ex_mem}, flush_v = {if_id, id_ex, ex_mem, mem_wb}
    always_comb begin
        stall_v    = 4'b0000;
        flush_v    = 4'b0000;
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        case (state_q)
            ST_RUN: begin
                if (mem_req && !mem_ready) begin
                    stall_v    = 4'b1111;
                    flush_v    = 4'b0001;
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WW'(1);
                end else if (branch_taken) begin
                    flush_v = 4'b1100;
                end else if (load_use) begin
                    stall_v = 4'b1100;
                    flush_v = 4'b0100;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else begin
                    stall_v = 4'b1111;
                    flush_v = 4'b0001;
                    if (wait_cnt_q == WW'(MEM_TIMEOUT)) begin
                        mem_err_d = 1'b1;
                        state_d   = ST_TRAP;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WW'(1);
                    end
                end
            end
            ST_TRAP: begin
                stall_v = 4'b1000;
                flush_v = 4'b1111;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        if (!rst) begin
            {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem} = 4'b0000;
            {flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb} = 4'b1111;
            fwd_a = FWD_RF;
            fwd_b = FWD_RF;
        end else begin
            {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem} = stall_v;
            {flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb} = flush_v;
            fwd_a = fwd_a_raw;
            fwd_b = fwd_b_raw;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
            if (stall_v[3] && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed bench for pipe_hazard_ctrl against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int TO = 4;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rs1 = '0, ex_rs2 = '0;
    logic id_rs1_used = 0, id_rs2_used = 0;
    logic [4:0] ex_wr_index = '0, mem_wr_index = '0, wb_wr_index = '0;
    logic ex_wr_en = 0, mem_wr_en = 0, wb_wr_en = 0;
    logic [1:0] ex_data_sel = '0, mem_data_sel = '0;
    logic branch_taken = 0, mem_req = 0, mem_ready = 0;
    logic stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
    logic flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
    logic [1:0] fwd_a, fwd_b;
    logic mem_err;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_wr_index(ex_wr_index), .ex_wr_en(ex_wr_en), .ex_data_sel(ex_data_sel),
        .mem_wr_index(mem_wr_index), .mem_wr_en(mem_wr_en), .mem_data_sel(mem_data_sel),
        .wb_wr_index(wb_wr_index), .wb_wr_en(wb_wr_en),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
        .stall_ex_mem(stall_ex_mem),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
        .flush_mem_wb(flush_mem_wb),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: how many wait cycles we are into a memory stall (0 = not waiting)
    bit m_trap = 0, m_err = 0;
    int m_waits = 0;
    int m_cnt = 0;

    function automatic logic [1:0] fwd_model(input logic [4:0] rs);
        if (rs == 0) return 2'd0;
        if (mem_wr_en && mem_data_sel != 2'd1 && mem_wr_index == rs) return 2'd1;
        if (wb_wr_en && wb_wr_index == rs) return 2'd2;
        return 2'd0;
    endfunction

    // Call with inputs settled shortly after a rising edge; returns shortly after the next one.
    task automatic cyc();
        bit sp, sif, sie, sem, fif, fie, fem, fmw;
        bit n_trap, n_err2;
        int n_waits, n_cnt;
        logic [1:0] fa, fb;
        bit lu;
        #1;
        if (!rst) begin
            m_trap = 0; m_err = 0; m_waits = 0; m_cnt = 0;
        end
        {sp, sif, sie, sem, fif, fie, fem, fmw} = '0;
        n_trap = m_trap; n_err2 = m_err; n_waits = m_waits;
        lu = ex_wr_en && ex_data_sel == 2'd1 && ex_wr_index != 0 &&
             ((id_rs1_used && id_rs1 == ex_wr_index) || (id_rs2_used && id_rs2 == ex_wr_index));
        if (m_trap) begin
            sp = 1; {fif, fie, fem, fmw} = 4'hF;
        end else if (m_waits > 0) begin
            if (mem_ready) n_waits = 0;
            else begin
                {sp, sif, sie, sem, fmw} = 5'h1F;
                if (m_waits == TO) begin n_trap = 1; n_err2 = 1; n_waits = 0; end
                else n_waits = m_waits + 1;
            end
        end else if (mem_req && !mem_ready) begin
            {sp, sif, sie, sem, fmw} = 5'h1F; n_waits = 1;
        end else if (branch_taken) begin
            fif = 1; fie = 1;
        end else if (lu) begin
            sp = 1; sif = 1; fie = 1;
        end
        fa = fwd_model(ex_rs1);
        fb = fwd_model(ex_rs2);
        if (!rst) begin
            {sp, sif, sie, sem} = '0; {fif, fie, fem, fmw} = 4'hF; fa = 0; fb = 0;
        end
        chk("ctrl", {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
                     flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb},
                    {sp, sif, sie, sem, fif, fie, fem, fmw});
        chk("fwd", {fwd_a, fwd_b}, {fa, fb});
        chk("mem_err", mem_err, m_err);
        chk("stall_cnt", stall_cnt, m_cnt);
        n_cnt = (sp && m_cnt < (1 << CW) - 1) ? m_cnt + 1 : m_cnt;
        @(posedge clk);
        if (rst) begin
            m_trap = n_trap; m_err = n_err2; m_waits = n_waits; m_cnt = n_cnt;
        end
        #1;
    endtask

    task automatic idle();
        id_rs1_used = 0; id_rs2_used = 0; ex_wr_en = 0; mem_wr_en = 0; wb_wr_en = 0;
        branch_taken = 0; mem_req = 0; mem_ready = 0;
        ex_rs1 = 0; ex_rs2 = 0; mem_wr_index = 0; wb_wr_index = 0;
    endtask

    task automatic set_load_use();
        ex_wr_index = 5; ex_data_sel = 2'b01; ex_wr_en = 1; id_rs1 = 5; id_rs1_used = 1;
    endtask

    initial begin
        idle();
        rst = 0;
        @(posedge clk); #1;
        cyc();
        chk("reset_flush", {flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb}, 4'hF);
        rst = 1;
        @(posedge clk); #1;

        // load-use then bubble
        set_load_use(); cyc();
        ex_wr_en = 0; #1;
        chk("lu_released", {stall_pc, stall_if_id, flush_id_ex}, 3'b000);
        cyc();
        chk("lu_cnt", stall_cnt, 1);
        // branch beats load-use
        set_load_use(); branch_taken = 1; cyc();
        idle();
        // 3-cycle memory wait
        mem_req = 1;
        repeat (3) cyc();
        mem_ready = 1; cyc();
        idle(); cyc();
        // timeout into trap, then reset clears
        mem_req = 1;
        repeat (TO + 3) cyc();
        chk("trap_err", mem_err, 1);
        idle(); rst = 0; cyc();
        rst = 1; cyc();
        // forwarding priorities
        ex_rs1 = 7; ex_rs2 = 7; mem_wr_index = 7; mem_wr_en = 1; mem_data_sel = 2'b00;
        wb_wr_index = 7; wb_wr_en = 1; cyc();
        mem_wr_en = 0; cyc();
        ex_rs1 = 0; ex_rs2 = 0; mem_wr_index = 0; wb_wr_index = 0; mem_wr_en = 1; cyc();
        idle();
        // counter saturation
        set_load_use();
        repeat (20) cyc();
        chk("cnt_sat", stall_cnt, 15);
        idle();

        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 39) != 0);
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            id_rs1_used = 1'($urandom); id_rs2_used = 1'($urandom);
            ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
            ex_wr_index = 5'($urandom_range(0, 3)); ex_wr_en = 1'($urandom);
            ex_data_sel = 2'($urandom);
            mem_wr_index = 5'($urandom_range(0, 3)); mem_wr_en = 1'($urandom);
            mem_data_sel = 2'($urandom);
            wb_wr_index = 5'($urandom_range(0, 3)); wb_wr_en = 1'($urandom);
            branch_taken = ($urandom_range(0, 3) == 0);
            mem_req = ($urandom_range(0, 3) == 0);
            mem_ready = ($urandom_range(0, 2) == 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
